// File: rtl/random_led_pwm_pkg.sv
// Shared types and helpers for random_led_pwm: FSM state encoding and the
// optional gamma curve applied to accepted samples.
package random_led_pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Squares the sample and keeps the top half, giving a rough perceptual curve.
  function automatic logic [15:0] gamma(input logic [15:0] sample,
                                        input int unsigned data_w);
    logic [31:0] sq;
    sq = 32'(sample) * 32'(sample);
    return 16'(sq >> data_w);
  endfunction

endpackage

// File: rtl/random_led_pwm_prescaler.sv
// Step-rate divider for random_led_pwm: free-running counter 0..PRESCALE-1
// with a synchronous clear; tick is high while the count sits at PRESCALE-1.
module pwm_prescaler #(
  parameter int PRESCALE = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/random_led_pwm.sv
// Random-brightness LED driver: accepts one LFSR sample per RUN, holds its duty
// for HOLD_PERIODS PWM periods. Define RANDOM_LED_PWM_GAMMA_EN for gamma-mapped duty.
// Handshake: a sample transfers on a rising edge where sample_valid && sample_ready;
// sample_ready is high only in IDLE, so at most one sample is in flight.
module random_led_pwm
  import random_led_pwm_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int PRESCALE     = 1024,
  parameter int HOLD_PERIODS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  output logic              led,
  output logic              busy
);

  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [DATA_W-1:0] PHASE_LAST = DATA_W'((1 << DATA_W) - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_PERIODS - 1);

  state_t            state;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] duty_in;
  logic [DATA_W-1:0] phase;
  logic [DATA_W-1:0] phase_inc;
  logic [HOLD_W-1:0] hold;
  logic              accept;
  logic              tick;

`ifdef RANDOM_LED_PWM_GAMMA_EN
  assign duty_in = DATA_W'(gamma(16'(sample_data), DATA_W));
`else
  assign duty_in = sample_data;
`endif

  assign accept    = (state == IDLE) && sample_valid && sample_ready;
  assign phase_inc = phase + 1'b1;

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .tick (tick)
  );

  // led is always the compare against the phase value being loaded this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      led          <= 1'b0;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      duty         <= '0;
      phase        <= '0;
      hold         <= '0;
    end else begin
      case (state)
        IDLE: begin
          sample_ready <= 1'b1;
          led          <= 1'b0;
          busy         <= 1'b0;
          if (accept) begin
            duty         <= duty_in;
            phase        <= '0;
            hold         <= '0;
            state        <= RUN;
            sample_ready <= 1'b0;
            busy         <= 1'b1;
            led          <= (duty_in != '0);
          end
        end
        RUN: begin
          if (tick) begin
            if (phase == PHASE_LAST) begin
              phase <= '0;
              if (hold == HOLD_LAST) begin
                state        <= IDLE;
                led          <= 1'b0;
                busy         <= 1'b0;
                sample_ready <= 1'b1;
              end else begin
                hold <= hold + 1'b1;
                led  <= (duty != '0);
              end
            end else begin
              phase <= phase_inc;
              led   <= (phase_inc < duty);
            end
          end else begin
            led <= (phase < duty);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_led_pwm.sv
// Directed bench for random_led_pwm with DATA_W=4, PRESCALE=2, HOLD_PERIODS=2.
module tb_random_led_pwm;

  localparam int DATA_W   = 4;
  localparam int PRESCALE = 2;
  localparam int HOLD     = 2;
  localparam int PERIOD   = 15;
  localparam int RUN_LEN  = HOLD * PERIOD * PRESCALE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_ready;
  logic              led;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] sample;
    int                duty;
  } vec_t;

  vec_t vecs[5];

  random_led_pwm #(
    .DATA_W      (DATA_W),
    .PRESCALE    (PRESCALE),
    .HOLD_PERIODS(HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .led         (led),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample, then checks every RUN cycle against the duty model.
  task automatic run_sample(input logic [DATA_W-1:0] data, input int duty,
                            input bit keep_valid);
    int n;
    n = 0;
    while (!sample_ready && n < 4) begin
      step();
      n++;
    end
    chk("ready_before_accept", sample_ready, 1'b1);
    sample_valid = 1'b1;
    sample_data  = data;
    step();
    if (!keep_valid) sample_valid = 1'b0;
    for (int k = 1; k <= RUN_LEN; k++) begin
      if (keep_valid) sample_data = DATA_W'($urandom_range(0, 15));
      chk("led_run", led, (((k - 1) / PRESCALE) % PERIOD) < duty);
      chk("busy_run", busy, 1'b1);
      chk("ready_run", sample_ready, 1'b0);
      step();
    end
    chk("ready_after_run", sample_ready, 1'b1);
    chk("busy_after_run", busy, 1'b0);
    chk("led_after_run", led, 1'b0);
  endtask

  initial begin
`ifdef RANDOM_LED_PWM_GAMMA_EN
    vecs[0] = '{4'd5,  1};
    vecs[1] = '{4'd15, 14};
    vecs[2] = '{4'd0,  0};
    vecs[3] = '{4'd1,  0};
    vecs[4] = '{4'd9,  5};
`else
    vecs[0] = '{4'd5,  5};
    vecs[1] = '{4'd15, 15};
    vecs[2] = '{4'd0,  0};
    vecs[3] = '{4'd1,  1};
    vecs[4] = '{4'd9,  9};
`endif

    // Reset: everything low while asserted, ready one edge after release.
    step();
    step();
    chk("rst_led", led, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", sample_ready, 1'b0);
    #2 rst_n = 1'b1;
    #1 chk("ready_before_edge", sample_ready, 1'b0);
    step();
    chk("ready_after_release", sample_ready, 1'b1);
    chk("idle_led", led, 1'b0);

    foreach (vecs[i]) run_sample(vecs[i].sample, vecs[i].duty, 1'b0);

    // Valid held through RUN with churning data; second accept lands right
    // on the edge after ready rises.
    run_sample(vecs[0].sample, vecs[0].duty, 1'b1);
    run_sample(vecs[4].sample, vecs[4].duty, 1'b0);

    // Asynchronous reset in the middle of a RUN.
    sample_valid = 1'b1;
    sample_data  = vecs[1].sample;
    step();
    sample_valid = 1'b0;
    for (int k = 1; k < 20; k++) step();
    chk("mid_led", led, 1'b1);
    chk("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_led", led, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_ready", sample_ready, 1'b0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk("ready_after_rerelease", sample_ready, 1'b1);
    run_sample(vecs[0].sample, vecs[0].duty, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
